// File: rtl/xrv1_pkg.sv
// Shared types and default widths for the xrv1 instruction-queue control slice.
//   ITAG_WIDTH    : itag width, queue depth is 1 << ITAG_WIDTH
//   RF_ADDR_WIDTH : register-file address width
//   NUM_RS        : source operands checked per issue
package xrv1_pkg;

    localparam int unsigned ITAG_WIDTH    = 3;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned NUM_RS        = 2;

    typedef logic [ITAG_WIDTH-1:0]    itag_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [ITAG_WIDTH:0]      occ_t;

    typedef enum logic [0:0] {
        IQ_RUN   = 1'b0,
        IQ_DRAIN = 1'b1
    } iq_state_e;

endpackage

// File: rtl/xrv1_rs_match.sv
// Per-source RAW comparator: flags every in-flight entry that writes rs_addr_i.
//   vld_i, rd_vld_i : registered entry valid / writes-rd flags
//   rd_addr_i       : registered entry rd addresses
//   rs_addr_i       : source register of the issuing instruction
//   conflict_o      : one bit per entry, x0 never conflicts
module xrv1_rs_match
    import xrv1_pkg::*;
#(
    parameter int unsigned ENTRIES_P = 8,
    parameter int unsigned ADDR_W_P  = RF_ADDR_WIDTH
) (
    input  logic [ENTRIES_P-1:0]               vld_i,
    input  logic [ENTRIES_P-1:0]               rd_vld_i,
    input  logic [ENTRIES_P-1:0][ADDR_W_P-1:0] rd_addr_i,
    input  logic [ADDR_W_P-1:0]                rs_addr_i,
    output logic [ENTRIES_P-1:0]               conflict_o
);

    always_comb begin
        conflict_o = '0;
        for (int unsigned k = 0; k < ENTRIES_P; k++) begin
            conflict_o[k] = vld_i[k] & rd_vld_i[k] & (rd_addr_i[k] == rs_addr_i)
                            & (rs_addr_i != '0);
        end
    end

endmodule

// File: rtl/xrv1_iqueue_ctrl.sv
// Instruction-tag scheduler: allocates itags at the tail on issue, frees them
// from the head by retire count, reports RAW conflicts per source operand and
// sequences flush and drain (fence).
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   issue_*                : dispatch handshake, rd/rs info, granted tag
//   retire_itag_o/cnt_i    : head pointer and entries retired this cycle
//   rs_conflict_o          : per-source in-flight writer vectors
//   iqueue_*_o             : entry state for the retire/writeback block
//   flush_i, drain_req_i   : discard all / stop issue until empty
//   drain_done_o           : one-cycle pulse when a drain completes
//   empty_o, full_o        : occupancy decodes
module xrv1_iqueue_ctrl
    import xrv1_pkg::*;
#(
    parameter int unsigned ITAG_WIDTH_P    = ITAG_WIDTH,
    parameter int unsigned rf_addr_width_p = RF_ADDR_WIDTH,
    localparam int unsigned iqueue_size_lp = 1 << ITAG_WIDTH_P,
    localparam int unsigned num_rs_lp      = NUM_RS
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             issue_vld_i,
    output logic                                             issue_rdy_o,
    input  logic                                             issue_rd_vld_i,
    input  logic [rf_addr_width_p-1:0]                       issue_rd_addr_i,
    input  logic [num_rs_lp-1:0][rf_addr_width_p-1:0]        issue_rs_addr_i,
    output logic [ITAG_WIDTH_P-1:0]                          issue_itag_o,
    output logic [ITAG_WIDTH_P-1:0]                          retire_itag_o,
    input  logic [ITAG_WIDTH_P-1:0]                          retire_cnt_i,
    output logic [num_rs_lp-1:0][iqueue_size_lp-1:0]         rs_conflict_o,
    output logic [iqueue_size_lp-1:0]                        iqueue_vld_o,
    output logic [iqueue_size_lp-1:0]                        iqueue_rd_vld_o,
    output logic [iqueue_size_lp-1:0][rf_addr_width_p-1:0]   iqueue_rd_addr_o,
    input  logic                                             flush_i,
    input  logic                                             drain_req_i,
    output logic                                             drain_done_o,
    output logic                                             empty_o,
    output logic                                             full_o
);

    localparam int unsigned OCC_W = ITAG_WIDTH_P + 1;

    logic [ITAG_WIDTH_P-1:0]                        head_q, head_d;
    logic [ITAG_WIDTH_P-1:0]                        tail_q, tail_d;
    logic [OCC_W-1:0]                               occ_q, occ_d;
    logic [iqueue_size_lp-1:0]                      vld_q, vld_d;
    logic [iqueue_size_lp-1:0]                      rd_vld_q, rd_vld_d;
    logic [iqueue_size_lp-1:0][rf_addr_width_p-1:0] rd_addr_q, rd_addr_d;
    iq_state_e                                      state_q;
    logic                                           drain_done_q;
    logic [ITAG_WIDTH_P-1:0]                        retire_cnt;
    logic                                           issue_fire;

    // Decodes use registered occupancy only, so a same-cycle retire never frees a slot.
    assign full_o        = (occ_q == OCC_W'(iqueue_size_lp));
    assign empty_o       = (occ_q == '0);
    assign issue_rdy_o   = (state_q == IQ_RUN) & ~full_o & ~flush_i;
    assign issue_fire    = issue_vld_i & issue_rdy_o;
    assign issue_itag_o  = tail_q;
    assign retire_itag_o = head_q;
    assign drain_done_o  = drain_done_q;

    assign iqueue_vld_o     = vld_q;
    assign iqueue_rd_vld_o  = rd_vld_q;
    assign iqueue_rd_addr_o = rd_addr_q;

    // Over-retire is illegal; clamp so the pointers stay consistent regardless.
    assign retire_cnt = ({1'b0, retire_cnt_i} > occ_q) ? occ_q[ITAG_WIDTH_P-1:0] : retire_cnt_i;

    // Entry and pointer next-state: flush wins over issue and retire.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        vld_d     = vld_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        if (flush_i) begin
            vld_d     = '0;
            rd_vld_d  = '0;
            rd_addr_d = '0;
            tail_d    = head_q;
            occ_d     = '0;
        end else begin
            // Entry k retires when its distance from head (mod depth) is below the count.
            for (int unsigned k = 0; k < iqueue_size_lp; k++) begin
                if ((ITAG_WIDTH_P'(k) - head_q) < retire_cnt) begin
                    vld_d[k]     = 1'b0;
                    rd_vld_d[k]  = 1'b0;
                    rd_addr_d[k] = '0;
                end
            end
            if (issue_fire) begin
                vld_d[tail_q]     = 1'b1;
                rd_vld_d[tail_q]  = issue_rd_vld_i & (issue_rd_addr_i != '0);
                rd_addr_d[tail_q] = issue_rd_addr_i;
                tail_d            = tail_q + ITAG_WIDTH_P'(1);
            end
            head_d = head_q + retire_cnt;
            occ_d  = occ_q + OCC_W'(issue_fire) - OCC_W'(retire_cnt);
        end
    end

    // State registers and RUN/DRAIN sequencing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            vld_q        <= '0;
            rd_vld_q     <= '0;
            rd_addr_q    <= '0;
            state_q      <= IQ_RUN;
            drain_done_q <= 1'b0;
        end else begin
            if (!flush_i) begin
                assert ({1'b0, retire_cnt_i} <= occ_q);
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            vld_q        <= vld_d;
            rd_vld_q     <= rd_vld_d;
            rd_addr_q    <= rd_addr_d;
            drain_done_q <= 1'b0;
            if (flush_i) begin
                state_q      <= IQ_RUN;
                drain_done_q <= (state_q == IQ_DRAIN);
            end else begin
                case (state_q)
                    IQ_RUN: begin
                        if (drain_req_i) begin
                            if (occ_q == '0) begin
                                drain_done_q <= 1'b1;
                            end else begin
                                state_q <= IQ_DRAIN;
                            end
                        end
                    end
                    IQ_DRAIN: begin
                        if (occ_q == '0) begin
                            state_q      <= IQ_RUN;
                            drain_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IQ_RUN;
                endcase
            end
        end
    end

    // One comparator array per source operand against registered entry state.
    for (genvar j = 0; j < num_rs_lp; j++) begin : g_rs
        xrv1_rs_match #(
            .ENTRIES_P (iqueue_size_lp),
            .ADDR_W_P  (rf_addr_width_p)
        ) u_rs_match (
            .vld_i      (vld_q),
            .rd_vld_i   (rd_vld_q),
            .rd_addr_i  (rd_addr_q),
            .rs_addr_i  (issue_rs_addr_i[j]),
            .conflict_o (rs_conflict_o[j])
        );
    end

endmodule

// File: tb/tb_xrv1_iqueue_ctrl.sv
// Directed bench for xrv1_iqueue_ctrl: granted itags are checked through a
// scoreboard queue; entry/pointer state against a small behavioural model.
module tb_xrv1_iqueue_ctrl;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            issue_vld_i;
    logic            issue_rdy_o;
    logic            issue_rd_vld_i;
    logic [4:0]      issue_rd_addr_i;
    logic [1:0][4:0] issue_rs_addr_i;
    logic [2:0]      issue_itag_o;
    logic [2:0]      retire_itag_o;
    logic [2:0]      retire_cnt_i;
    logic [1:0][7:0] rs_conflict_o;
    logic [7:0]      iqueue_vld_o;
    logic [7:0]      iqueue_rd_vld_o;
    logic [7:0][4:0] iqueue_rd_addr_o;
    logic            flush_i;
    logic            drain_req_i;
    logic            drain_done_o;
    logic            empty_o;
    logic            full_o;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference state
    int              m_head, m_tail, m_occ, m_state;
    logic            m_done;
    logic [7:0]      m_vld, m_rdv;
    logic [7:0][4:0] m_rda;
    int              sb_q[$];

    always #5 clk_i = ~clk_i;

    xrv1_iqueue_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_vld_i      (issue_vld_i),
        .issue_rdy_o      (issue_rdy_o),
        .issue_rd_vld_i   (issue_rd_vld_i),
        .issue_rd_addr_i  (issue_rd_addr_i),
        .issue_rs_addr_i  (issue_rs_addr_i),
        .issue_itag_o     (issue_itag_o),
        .retire_itag_o    (retire_itag_o),
        .retire_cnt_i     (retire_cnt_i),
        .rs_conflict_o    (rs_conflict_o),
        .iqueue_vld_o     (iqueue_vld_o),
        .iqueue_rd_vld_o  (iqueue_rd_vld_o),
        .iqueue_rd_addr_o (iqueue_rd_addr_o),
        .flush_i          (flush_i),
        .drain_req_i      (drain_req_i),
        .drain_done_o     (drain_done_o),
        .empty_o          (empty_o),
        .full_o           (full_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic rdv, input logic [4:0] rda,
                         input logic [2:0] rcnt, input logic fl, input logic dr);
        issue_vld_i     = vld;
        issue_rd_vld_i  = rdv;
        issue_rd_addr_i = rda;
        retire_cnt_i    = rcnt;
        flush_i         = fl;
        drain_req_i     = dr;
    endtask

    task automatic conf(input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [7:0] e0, input logic [7:0] e1);
        issue_rs_addr_i[0] = rs0;
        issue_rs_addr_i[1] = rs1;
        #1;
        check("rs_conflict0", 64'(rs_conflict_o[0]), 64'(e0));
        check("rs_conflict1", 64'(rs_conflict_o[1]), 64'(e1));
    endtask

    task automatic check_state();
        check("retire_itag", 64'(retire_itag_o), 64'(m_head));
        check("issue_itag",  64'(issue_itag_o),  64'(m_tail));
        check("iqueue_vld",  64'(iqueue_vld_o),  64'(m_vld));
        check("iqueue_rdv",  64'(iqueue_rd_vld_o), 64'(m_rdv));
        check("iqueue_rda",  64'(iqueue_rd_addr_o), 64'(m_rda));
        check("empty",       64'(empty_o), 64'(m_occ == 0));
        check("full",        64'(full_o),  64'(m_occ == 8));
        check("drain_done",  64'(drain_done_o), 64'(m_done));
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // handshake, advances the model across one rising edge, checks state.
    task automatic tick();
        logic exp_rdy;
        logic grant;
        int   occ_old;
        int   idx;
        #1;
        exp_rdy = (m_state == 0) && (m_occ != 8) && !flush_i;
        if (rst_ni) check("issue_rdy", 64'(issue_rdy_o), 64'(exp_rdy));
        grant = rst_ni && issue_vld_i && exp_rdy;
        if (grant) sb_q.push_back(m_tail);
        if (rst_ni && issue_vld_i && issue_rdy_o) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL grant_unexpected observed=%0d expected=none", issue_itag_o);
            end
            if (sb_q.size() != 0) check("granted_itag", 64'(issue_itag_o), 64'(sb_q.pop_front()));
        end
        if (!rst_ni) begin
            m_head = 0; m_tail = 0; m_occ = 0; m_state = 0; m_done = 1'b0;
            m_vld = '0; m_rdv = '0; m_rda = '0;
            sb_q.delete();
        end else if (flush_i) begin
            m_done  = (m_state == 1);
            m_state = 0;
            m_vld = '0; m_rdv = '0; m_rda = '0;
            m_tail = m_head;
            m_occ  = 0;
        end else begin
            occ_old = m_occ;
            m_done  = 1'b0;
            for (int i = 0; i < int'(retire_cnt_i); i++) begin
                idx = (m_head + i) % 8;
                m_vld[idx] = 1'b0; m_rdv[idx] = 1'b0; m_rda[idx] = '0;
            end
            m_head = (m_head + int'(retire_cnt_i)) % 8;
            if (grant) begin
                m_vld[m_tail] = 1'b1;
                m_rdv[m_tail] = issue_rd_vld_i && (issue_rd_addr_i != 5'd0);
                m_rda[m_tail] = issue_rd_addr_i;
                m_tail = (m_tail + 1) % 8;
            end
            m_occ = m_occ + int'(grant) - int'(retire_cnt_i);
            if (m_state == 0) begin
                if (drain_req_i) begin
                    if (occ_old == 0) m_done = 1'b1;
                    else m_state = 1;
                end
            end else if (occ_old == 0) begin
                m_state = 0;
                m_done  = 1'b1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_state();
    endtask

    initial begin
        rst_ni = 1'b0;
        issue_rs_addr_i = '0;
        drive(0, 0, 5'd0, 3'd0, 0, 0);
        @(negedge clk_i);
        tick();
        tick();
        rst_ni = 1'b1;
        conf(5'd5, 5'd10, 8'h00, 8'h00);

        // Fill: 9 back-to-back requests, tags 0..7 granted, 9th refused
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 5'(10 + i), 3'd0, 0, 0);
            tick();
            if (i == 7) check("full_after_fill", 64'(full_o), 64'd1);
        end
        drive(0, 0, 5'd0, 3'd0, 0, 0);
        conf(5'd12, 5'd0, 8'b0000_0100, 8'h00);

        // Bulk retire across the wrap, then refill with tags 0,1,2
        drive(0, 0, 5'd0, 3'd3, 0, 0);
        tick();
        check("head_after_bulk", 64'(retire_itag_o), 64'd3);
        drive(1, 1, 5'd5, 3'd0, 0, 0); tick();
        drive(1, 1, 5'd0, 3'd0, 0, 0); tick();
        drive(1, 1, 5'd5, 3'd0, 0, 0);
        conf(5'd5, 5'd0, 8'b0000_0001, 8'h00);
        tick();
        drive(0, 0, 5'd0, 3'd0, 0, 0);
        conf(5'd5, 5'd0, 8'b0000_0101, 8'h00);
        check("full_after_refill", 64'(full_o), 64'd1);

        // Simultaneous issue/retire while full: no grant now, grant next cycle
        drive(1, 0, 5'd0, 3'd1, 0, 0); tick();
        check("empty_not_full", 64'(full_o), 64'd0);
        drive(1, 0, 5'd0, 3'd0, 0, 0); tick();

        // Retire 5 (entry 0 retiring still reports its conflict), leaving 3 in flight
        drive(0, 0, 5'd0, 3'd5, 0, 0);
        conf(5'd5, 5'd0, 8'b0000_0101, 8'h00);
        tick();

        // Drain with 3 in flight
        drive(0, 0, 5'd0, 3'd0, 0, 1); tick();
        drive(1, 1, 5'd7, 3'd2, 0, 0); tick();
        drive(1, 1, 5'd7, 3'd1, 0, 0); tick();
        drive(0, 0, 5'd0, 3'd0, 0, 0); tick();
        check("drain_done_pulse", 64'(drain_done_o), 64'd1);
        check("rdy_after_drain", 64'(issue_rdy_o), 64'd1);
        tick();
        check("drain_done_single", 64'(drain_done_o), 64'd0);

        // Drain request while already empty
        drive(0, 0, 5'd0, 3'd0, 0, 1); tick();
        drive(0, 0, 5'd0, 3'd0, 0, 0); tick();

        // Flush with 4 in flight; issue and retire in the flush cycle are ignored
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'(3 + i), 3'd0, 0, 0); tick();
        end
        drive(1, 1, 5'd9, 3'd2, 1, 0); tick();
        drive(0, 0, 5'd0, 3'd0, 0, 0);
        check("empty_after_flush", 64'(empty_o), 64'd1);
        conf(5'd3, 5'd5, 8'h00, 8'h00);

        // Flush while draining pulses drain_done
        drive(1, 1, 5'd8, 3'd0, 0, 0); tick();
        drive(1, 1, 5'd9, 3'd0, 0, 0); tick();
        drive(0, 0, 5'd0, 3'd0, 0, 1); tick();
        drive(0, 0, 5'd0, 3'd0, 1, 0); tick();
        check("flush_drain_done", 64'(drain_done_o), 64'd1);
        drive(0, 0, 5'd0, 3'd0, 0, 0); tick();

        // Mid-stream reset discards everything
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(20 + i), 3'd0, 0, 0); tick();
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("vld_after_rst", 64'(iqueue_vld_o), 64'd0);
        check("head_after_rst", 64'(retire_itag_o), 64'd0);
        drive(1, 1, 5'd4, 3'd0, 0, 0); tick();
        drive(0, 0, 5'd0, 3'd0, 0, 0); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xrv1_iqueue_ctrl.md
Name: xrv1_iqueue_ctrl

Overview:
Instruction-tag scheduler for the out-of-order completion / in-order retire backend. It allocates itags at issue, tracks in-flight entries (valid, rd valid, rd address) and frees them from the head by the retire block's retire count. It drives the iqueue state, issue/retire pointers and per-source RAW conflict vectors that the retire/writeback block consumes. It also provides flush and drain (fence) sequencing.

Parameters:
ITAG_WIDTH_P, 3, itag width; queue depth iqueue_size_lp = 1<<ITAG_WIDTH_P (derived, not overridable)
rf_addr_width_p, 5, register-file address width
num_rs_lp, 2, source operands checked per issue

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active-low
issue_vld_i  in  1  dispatch requests an itag
issue_rdy_o  out  1  itag available and state RUN
issue_rd_vld_i  in  1  instruction writes rd
issue_rd_addr_i  in  rf_addr_width_p  destination register
issue_rs_addr_i  in  num_rs_lp x rf_addr_width_p  source registers of the issuing instruction
issue_itag_o  out  ITAG_WIDTH_P  tail pointer: tag granted on this cycle's handshake
retire_itag_o  out  ITAG_WIDTH_P  head pointer (oldest in-flight)
retire_cnt_i  in  ITAG_WIDTH_P  entries retired this cycle
rs_conflict_o  out  num_rs_lp x iqueue_size_lp  in-flight entries writing each rs
iqueue_vld_o  out  iqueue_size_lp  entry valid
iqueue_rd_vld_o  out  iqueue_size_lp  entry writes rd
iqueue_rd_addr_o  out  iqueue_size_lp x rf_addr_width_p  entry rd address
flush_i  in  1  discard all in-flight entries
drain_req_i  in  1  fence: stop issue until empty
drain_done_o  out  1  one-cycle pulse when the drain completes
empty_o  out  1  occupancy == 0
full_o  out  1  occupancy == iqueue_size_lp

Behaviour:
- Reset (rst_ni=0 at posedge): head=tail=0, occupancy=0, all vld/rd_vld=0, rd_addr=0, state RUN, drain_done_o=0. Outputs after reset: issue_rdy_o=1, empty_o=1, full_o=0, rs_conflict_o=0. Reset mid-operation discards everything.
- Occupancy counter is ITAG_WIDTH_P+1 bits. Pointers are ITAG_WIDTH_P bits and wrap modulo iqueue_size_lp.
- issue_rdy_o = (state==RUN) & ~full_o & ~flush_i. It is computed from registered occupancy only; a same-cycle retire does not free a slot for same-cycle issue.
- Issue handshake (issue_vld_i & issue_rdy_o):
  - Next cycle: entry[tail].vld=1, rd_vld = issue_rd_vld_i & (issue_rd_addr_i!=0), rd_addr=issue_rd_addr_i.
  - tail increments and occupancy increments.
- Retire: entries head..head+retire_cnt_i-1 are cleared next cycle; head += retire_cnt_i, occupancy -= retire_cnt_i.
- Simultaneous issue and retire: both apply; occupancy += 1 - retire_cnt_i.
- retire_cnt_i > occupancy is illegal. An assertion fires and the count is clamped to occupancy.
- rs_conflict_o[j][k] = vld[k] & rd_vld[k] & (rd_addr[k]==issue_rs_addr_i[j]) & (issue_rs_addr_i[j]!=0).
  - Combinational on issue_rs_addr_i, evaluated against registered entry state.
  - Entries retiring this cycle still report a conflict.
  - The entry being allocated this cycle is never included.
- FSM states: RUN, DRAIN.
  - RUN -> DRAIN when drain_req_i=1 and occupancy!=0.
  - RUN with drain_req_i=1 and occupancy==0: pulse drain_done_o next cycle and stay in RUN.
  - DRAIN: issue_rdy_o=0. Exit to RUN on the cycle the registered occupancy is 0, with drain_done_o=1 for exactly that one cycle.
  - drain_req_i is sampled only in RUN.
- Flush (flush_i=1): next cycle all vld/rd_vld=0, tail<=head, occupancy=0.
  - Issue and retire_cnt_i are ignored in the flush cycle.
  - State goes to RUN. If a drain was active, drain_done_o pulses.
- empty_o/full_o are decoded from registered occupancy.

Decomposition:
- Package xrv1_pkg:
  - itag_t (logic [ITAG_WIDTH_P-1:0])
  - rf_addr_t
  - iq_state_e {IQ_RUN, IQ_DRAIN}
  - occupancy type of ITAG_WIDTH_P+1 bits
- Sub-module xrv1_rs_match: per-source comparator array producing one iqueue_size_lp-bit conflict vector. It is instantiated num_rs_lp times.

Test Plan:
1. Fill: 9 back-to-back issue_vld with retire_cnt_i=0 -> itags 0..7 granted, full_o=1 after the 8th, issue_rdy_o=0 on the 9th.
2. Wrap/bulk retire: from full, retire_cnt_i=3 -> head=3, occupancy=5. Then 3 issues -> tags 0,1,2; occupancy=8.
3. Conflict: issue rd=x5 as tag 0, rd=x0 as tag 1, rd=x5 as tag 2; then rs_addr={x5,x0} -> rs_conflict_o[0]=8'b00000101, rs_conflict_o[1]=0.
4. Simultaneous: occupancy=8, issue_vld=1, retire_cnt_i=1 -> no grant this cycle, occupancy=7; grant on the next cycle.
5. Drain: 3 in flight, drain_req_i pulse -> issue_rdy_o=0; retire 2 then 1 -> drain_done_o high one cycle, then issue_rdy_o=1.
6. Flush and reset: 4 in flight plus flush_i -> next cycle empty_o=1, tail==head, rs_conflict_o=0. Mid-stream rst_ni=0 -> head=tail=0, all vld=0.
